scan_loader: RTL and testbench
==============================

Name: scan_loader

Overview:
- Host-side front end that sits directly upstream of the accumulator microcontroller top and drives its scan_enable, scan_in and proc_en pins.
- Converts a byte-stream command interface into bit-serial scan-chain exchanges.
- Each exchange shifts a new image into the chain and captures the old image from scan_out.
- Also runs the processor for a bounded number of cycles, or until halt.

Parameters:
- CHAIN_LEN, 280, total scan-chain length in bits (control unit + PC 5 + IR 8 + ACC 8 + memory 256).
- CNT_W, 16, width of the run-cycle limit and cycle counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  0=EXCHANGE, 1=RUN, 2=STOP, 3=reserved (treated as NOP).
- cmd_arg  in  CNT_W  RUN cycle limit; 0 = unlimited.
- in_valid  in  1  image byte valid.
- in_ready  out  1  image byte accepted.
- in_data  in  8  image byte.
- out_valid  out  1  captured byte valid.
- out_ready  in  1  captured byte consumed.
- out_data  out  8  captured byte.
- scan_enable  out  1  to core.
- scan_in  out  1  to core.
- proc_en  out  1  to core.
- scan_out  in  1  from core (chain tail).
- halt  in  1  from core.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when EXCHANGE or RUN completes.
- done_reason  out  2  0=exchange, 1=halt, 2=limit, 3=stop; held until next done.
- cycles  out  CNT_W  proc_en cycles elapsed in the last/current RUN; saturates at all-ones.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - cmd_ready = 1 after reset (cmd_ready = IDLE || state==RUN). 0 is never driven during reset since state is IDLE.
- States: IDLE, SHIFT, FLUSH, RUN.
- IDLE:
  - Accepts any command.
  - EXCHANGE -> SHIFT, bit counter = 0.
  - RUN -> RUN, cycles = 0.
  - STOP and NOP complete silently with no done pulse.
- SHIFT, byte order and bit packing:
  - NBYTES = ceil(CHAIN_LEN/8).
  - Input bytes are consumed in shift order, bit 0 first.
  - In the final byte, bits beyond CHAIN_LEN are ignored.
- SHIFT, per-cycle rule:
  - A shift cycle occurs iff a current input byte is held AND the output holding byte is not full.
  - On a shift cycle: scan_enable=1, scan_in = current input bit, and scan_out is sampled into the capture shifter at that same clock edge.
  - Otherwise scan_enable=0 (stall). The core is then frozen, since proc_en=0 and scan_enable=0.
  - proc_en is always 0 in SHIFT and FLUSH.
- SHIFT, byte hand-off:
  - in_ready=1 only when no input byte is held; the byte is loaded on the handshake.
  - Every 8 captured bits (and at bit CHAIN_LEN) the capture byte moves to the output register and out_valid=1.
  - Unused MSBs of the final output byte are 0.
  - Output register clears on out_valid && out_ready. Single output register, no FIFO.
- SHIFT -> FLUSH after bit CHAIN_LEN-1 is shifted. Exactly CHAIN_LEN scan_enable cycles occur per EXCHANGE.
- FLUSH: wait until the final output byte is accepted, then pulse done with reason 0 and go to IDLE.
- Extra input bytes beyond NBYTES are not accepted (in_ready=0 outside SHIFT).
- RUN:
  - proc_en=1 and scan_enable=0; cycles increments each cycle.
  - Exit to IDLE with a done pulse, with priority: STOP cmd accepted > halt==1 (reason 1) > cycles+1==cmd_arg when limit != 0 (reason 2).
  - proc_en deasserts in the cycle after the terminating condition is observed.
  - If halt is already 1 on RUN entry: exactly one proc_en cycle, then done reason 1.
- STOP in SHIFT is not accepted (cmd_ready=0). An exchange always completes.
- Reset mid-operation: asynchronous return to IDLE with all outputs 0. The chain's partial contents are undefined; the host must re-EXCHANGE.

Decomposition:
- Shared package scan_loader_pkg:
  - cmd_op encodings.
  - done_reason encodings.
  - state enum.
  - NBYTES function.
- One natural sub-module: scan_byte_serdes, an 8-bit in/out shift pair with byte-valid flags and handshakes.
- Top-level FSM, counters and RUN logic remain in scan_loader.

Test Plan:
- Reset then EXCHANGE with CHAIN_LEN=280 and 35 bytes 0x00..0x22 -> exactly 280 scan_enable cycles. scan_in stream equals the bytes LSB-first. done reason 0 after the 35th out byte is accepted.
- Second EXCHANGE of 35 arbitrary bytes -> captured out_data equals the first image byte-for-byte (using a behavioural chain model, or the real core with proc_en low).
- EXCHANGE with in_valid dropping every 3rd cycle and out_ready held low for 20 cycles -> scan_enable low during every stall. No bit lost or duplicated; images still match.
- RUN with cmd_arg=10 while halt stays 0 -> proc_en high exactly 10 cycles; done reason 2; cycles=10.
- RUN with cmd_arg=0 and halt rising after 7 cycles -> proc_en drops next cycle; done reason 1. A STOP during a second RUN gives done reason 3.
- Assert rst mid-SHIFT at bit 100 -> all outputs 0 immediately. A new EXCHANGE then runs the full 280 bits.

Source files
------------

// File: rtl/scan_loader_pkg.sv
// Shared encodings for the scan loader: command opcodes, completion reasons,
// FSM states and the image byte-count helper.
package scan_loader_pkg;

  typedef enum logic [1:0] {
    OP_EXCHANGE = 2'd0,
    OP_RUN      = 2'd1,
    OP_STOP     = 2'd2,
    OP_NOP      = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    RSN_EXCHANGE = 2'd0,
    RSN_HALT     = 2'd1,
    RSN_LIMIT    = 2'd2,
    RSN_STOP     = 2'd3
  } done_reason_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FLUSH = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  function automatic int nbytes(input int chain_len);
    return (chain_len + 7) / 8;
  endfunction

endpackage

// File: rtl/scan_loader_serdes.sv
// Byte-to-bit serializer feeding scan_in and bit-to-byte capture of scan_out.
// Input and capture bit positions advance together on every shift cycle.
module scan_byte_serdes (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_en_i,
  input  logic       in_valid_i,
  input  logic [7:0] in_data_i,
  output logic       in_ready_o,
  output logic       in_held_o,
  output logic       cur_bit_o,
  input  logic       shift_i,
  input  logic       last_i,
  input  logic       scan_out_i,
  input  logic       out_ready_i,
  output logic       out_valid_o,
  output logic [7:0] out_data_o
);

  logic [7:0] in_q;
  logic       in_full_q, in_full_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] cap_q, cap_d;
  logic [7:0] out_q, out_d;
  logic       out_valid_q, out_valid_d;
  logic       in_take;

  assign in_ready_o  = in_en_i & ~in_full_q;
  assign in_take     = in_valid_i & in_ready_o;
  assign in_held_o   = in_full_q;
  assign cur_bit_o   = in_q[idx_q];
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_q;

  always_comb begin
    in_full_d   = in_full_q;
    idx_d       = idx_q;
    cap_d       = cap_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (in_take) in_full_d = 1'b1;
    if (out_valid_q && out_ready_i) out_valid_d = 1'b0;
    if (shift_i) begin
      cap_d[idx_q] = scan_out_i;
      // Byte boundary or chain end: release the input byte, publish the capture.
      if (idx_q == 3'd7 || last_i) begin
        in_full_d   = 1'b0;
        idx_d       = 3'd0;
        out_d       = cap_d;
        out_valid_d = 1'b1;
        cap_d       = 8'h00;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_full_q   <= 1'b0;
      idx_q       <= 3'd0;
      cap_q       <= 8'h00;
      out_q       <= 8'h00;
      out_valid_q <= 1'b0;
    end else begin
      in_full_q   <= in_full_d;
      idx_q       <= idx_d;
      cap_q       <= cap_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (in_take) in_q <= in_data_i;
  end

endmodule

// File: rtl/scan_loader.sv
// Host front end for the accumulator core: byte-stream scan exchanges and
// bounded processor runs, driving scan_enable, scan_in and proc_en.
module scan_loader
  import scan_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 280,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_arg,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             scan_enable,
  output logic             scan_in,
  output logic             proc_en,
  input  logic             scan_out,
  input  logic             halt,
  output logic             busy,
  output logic             done,
  output logic [1:0]       done_reason,
  output logic [CNT_W-1:0] cycles
);

  localparam int BIT_W = $clog2(CHAIN_LEN);

  state_e           state_q, state_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic             done_q, done_d;
  logic [1:0]       reason_q, reason_d;

  logic             cmd_take, shift, last, in_held, cur_bit;
  logic [CNT_W:0]   cyc_next;

  assign cmd_ready   = (state_q == ST_IDLE) || (state_q == ST_RUN);
  assign cmd_take    = cmd_valid && cmd_ready;
  // A shift needs a held input bit and room for the captured bit.
  assign shift       = (state_q == ST_SHIFT) && in_held && !out_valid;
  assign last        = shift && (bit_q == BIT_W'(CHAIN_LEN - 1));
  assign scan_enable = shift;
  assign scan_in     = shift & cur_bit;
  assign proc_en     = (state_q == ST_RUN);
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign done_reason = reason_q;
  assign cycles      = cycles_q;
  assign cyc_next    = {1'b0, cycles_q} + {{CNT_W{1'b0}}, 1'b1};

  scan_byte_serdes u_serdes (
    .clk         (clk),
    .rst         (rst),
    .in_en_i     (state_q == ST_SHIFT),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .in_held_o   (in_held),
    .cur_bit_o   (cur_bit),
    .shift_i     (shift),
    .last_i      (last),
    .scan_out_i  (scan_out),
    .out_ready_i (out_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data)
  );

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    cycles_d = cycles_q;
    limit_d  = limit_q;
    done_d   = 1'b0;
    reason_d = reason_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_take) begin
          case (cmd_op)
            OP_EXCHANGE: begin
              state_d = ST_SHIFT;
              bit_d   = '0;
            end
            OP_RUN: begin
              state_d  = ST_RUN;
              cycles_d = '0;
              limit_d  = cmd_arg;
            end
            default: ;
          endcase
        end
      end
      ST_SHIFT: begin
        if (shift) begin
          bit_d = bit_q + BIT_W'(1);
          if (last) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (out_valid && out_ready) begin
          state_d  = ST_IDLE;
          done_d   = 1'b1;
          reason_d = RSN_EXCHANGE;
        end
      end
      ST_RUN: begin
        if (cycles_q != {CNT_W{1'b1}}) cycles_d = cyc_next[CNT_W-1:0];
        // Exit priority: host STOP, then core halt, then cycle limit.
        if (cmd_take && cmd_op == OP_STOP) begin
          state_d  = ST_IDLE;
          done_d   = 1'b1;
          reason_d = RSN_STOP;
        end else if (halt) begin
          state_d  = ST_IDLE;
          done_d   = 1'b1;
          reason_d = RSN_HALT;
        end else if (limit_q != '0 && cyc_next == {1'b0, limit_q}) begin
          state_d  = ST_IDLE;
          done_d   = 1'b1;
          reason_d = RSN_LIMIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      bit_q    <= '0;
      cycles_q <= '0;
      limit_q  <= '0;
      done_q   <= 1'b0;
      reason_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      cycles_q <= cycles_d;
      limit_q  <= limit_d;
      done_q   <= done_d;
      reason_q <= reason_d;
    end
  end

endmodule

// File: tb/tb_scan_loader.sv
// Bench for scan_loader: behavioural scan-chain model, exchange sequences,
// table-driven and randomized RUN checks against a reference model.
module tb_scan_loader;
  import scan_loader_pkg::*;

  localparam int CHAIN_LEN = 280;
  localparam int CNT_W     = 16;
  localparam int NB        = nbytes(CHAIN_LEN);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'd0;
  logic [CNT_W-1:0] cmd_arg = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_data = 8'h00;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [7:0]       out_data;
  logic             scan_enable, scan_in, proc_en;
  logic             scan_out;
  logic             halt = 1'b0;
  logic             busy, done;
  logic [1:0]       done_reason;
  logic [CNT_W-1:0] cycles;

  scan_loader #(.CHAIN_LEN(CHAIN_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .scan_enable(scan_enable), .scan_in(scan_in),
    .proc_en(proc_en), .scan_out(scan_out), .halt(halt), .busy(busy),
    .done(done), .done_reason(done_reason), .cycles(cycles)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scan chain as a first-in first-out bit line: the tail leaves on scan_out.
  bit   chain[$];
  logic se_s, si_s;
  always @(negedge clk) begin
    se_s = scan_enable;
    si_s = scan_in;
  end
  always @(posedge clk) begin
    if (se_s && !rst) begin
      void'(chain.pop_front());
      chain.push_back(si_s);
    end
    scan_out <= chain[0];
  end

  logic [7:0] img[NB];
  logic [7:0] exp_cap[NB];

  typedef struct {
    logic [CNT_W-1:0] arg;
    int               halt_at;
    int               stop_at;
    int               exp_pe;
    logic [1:0]       exp_rsn;
  } run_vec_t;

  run_vec_t tbl[8];

  task automatic check_idle(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_scan_enable"}, scan_enable, 0);
    chk({tag, "_scan_in"}, scan_in, 0);
    chk({tag, "_proc_en"}, proc_en, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_done_reason"}, done_reason, 0);
    chk({tag, "_cycles"}, cycles, 0);
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [CNT_W-1:0] arg);
    int t;
    t = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    @(negedge clk);
    while (!cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_accept", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic exchange(input int drop_every, input int hold_low, input bit rnd,
                          input int abort_at);
    int         in_idx, nse, nout, cyc;
    bit         fin;
    logic [7:0] sin_b[NB];
    for (int b = 0; b < NB; b++) begin
      sin_b[b] = 8'h00;
      for (int k = 0; k < 8; k++)
        exp_cap[b][k] = (8 * b + k < CHAIN_LEN) ? chain[8 * b + k] : 1'b0;
    end
    send_cmd(OP_EXCHANGE, '0);
    in_idx = 0; nse = 0; nout = 0; cyc = 0; fin = 0;
    while (!fin && cyc < 6000) begin
      in_valid  = !(drop_every > 0 && (cyc % drop_every) == drop_every - 1) &&
                  (!rnd || $urandom_range(0, 3) != 0);
      in_data   = (in_idx < NB) ? img[in_idx] : 8'hEE;
      out_ready = (cyc >= hold_low) && (!rnd || $urandom_range(0, 2) != 0);
      @(negedge clk);
      if (in_valid && in_ready) in_idx++;
      if (out_valid && out_ready) begin
        if (nout < NB) chk("cap_byte", out_data, exp_cap[nout]);
        nout++;
      end
      if (scan_enable) begin
        if (nse < CHAIN_LEN) sin_b[nse / 8][nse % 8] = scan_in;
        nse++;
        chk("shift_while_out_full", out_valid, 0);
      end
      if (busy) chk("cmd_ready_busy", cmd_ready, 0);
      chk("proc_en_exchange", proc_en, 0);
      if (done) begin
        fin = 1;
        chk("xchg_reason", done_reason, RSN_EXCHANGE);
      end
      if (abort_at >= 0 && nse == abort_at) begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2 rst = 1'b1;
        #1 check_idle("mid_shift_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("xchg_done_seen", fin, 1);
    chk("xchg_scan_cycles", nse, CHAIN_LEN);
    chk("xchg_out_bytes", nout, NB);
    chk("xchg_in_accepted", in_idx, NB);
    for (int b = 0; b < NB; b++) chk("scan_in_byte", sin_b[b], img[b]);
    @(negedge clk);
    chk("xchg_done_pulse", done, 0);
    chk("xchg_idle_in_ready", in_ready, 0);
    chk("xchg_idle_busy", busy, 0);
    @(posedge clk);
    #1;
  endtask

  // Reference: first terminating condition in priority order decides the run.
  task automatic run_model(input logic [CNT_W-1:0] arg, input int halt_at, input int stop_at,
                           output int pe, output logic [1:0] rsn);
    pe  = -1;
    rsn = 2'd0;
    for (int k = 0; k < 1000 && pe < 0; k++) begin
      if (k == stop_at) begin
        pe = k + 1; rsn = 2'd3;
      end else if (halt_at >= 0 && k >= halt_at) begin
        pe = k + 1; rsn = 2'd1;
      end else if (arg != 0 && k + 1 == int'(arg)) begin
        pe = k + 1; rsn = 2'd2;
      end
    end
  endtask

  task automatic do_run(input run_vec_t v, input string tag);
    int pe;
    bit fin;
    pe = 0; fin = 0;
    halt = (v.halt_at == 0);
    send_cmd(OP_RUN, v.arg);
    for (int k = 0; k < 300 && !fin; k++) begin
      halt      = (v.halt_at >= 0 && k >= v.halt_at);
      cmd_valid = (k == v.stop_at);
      cmd_op    = OP_STOP;
      cmd_arg   = '0;
      @(negedge clk);
      if (proc_en) pe++;
      chk({tag, "_scan_enable"}, scan_enable, 0);
      if (done) begin
        fin = 1;
        chk({tag, "_pe_drop"}, proc_en, 0);
      end
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    halt      = 1'b0;
    chk({tag, "_done_seen"}, fin, 1);
    chk({tag, "_pe_cycles"}, pe, v.exp_pe);
    chk({tag, "_reason"}, done_reason, v.exp_rsn);
    chk({tag, "_cycles"}, cycles, v.exp_pe);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    run_vec_t   rv;
    int         pe;
    logic [1:0] rsn;

    for (int i = 0; i < CHAIN_LEN; i++) begin
      logic [7:0] p;
      p = 8'hA5 ^ 8'(i / 8);
      chain.push_back(p[i % 8]);
    end
    tbl[0] = '{16'd10, -1, -1, 10, 2'd2};
    tbl[1] = '{16'd0,   7, -1,  8, 2'd1};
    tbl[2] = '{16'd0,  -1,  5,  6, 2'd3};
    tbl[3] = '{16'd0,   0, -1,  1, 2'd1};
    tbl[4] = '{16'd1,  -1, -1,  1, 2'd2};
    tbl[5] = '{16'd3,   2, -1,  3, 2'd1};
    tbl[6] = '{16'd5,   4,  4,  5, 2'd3};
    tbl[7] = '{16'd20,  3, -1,  4, 2'd1};

    repeat (3) @(posedge clk);
    #1 check_idle("reset_held");
    rst = 1'b0;
    @(posedge clk);
    #1 check_idle("after_reset");

    for (int i = 0; i < NB; i++) img[i] = 8'(i);
    exchange(0, 0, 1'b0, -1);

    for (int i = 0; i < NB; i++) img[i] = 8'($urandom);
    exchange(3, 20, 1'b0, -1);

    for (int i = 0; i < NB; i++) img[i] = 8'($urandom);
    exchange(0, 0, 1'b1, -1);

    for (int i = 0; i < 8; i++) do_run(tbl[i], $sformatf("run_tbl%0d", i));

    for (int i = 0; i < 20; i++) begin
      rv.arg     = CNT_W'($urandom_range(0, 15));
      rv.halt_at = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 20));
      rv.stop_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1;
      if (rv.arg == 0 && rv.halt_at < 0 && rv.stop_at < 0) rv.halt_at = 5;
      run_model(rv.arg, rv.halt_at, rv.stop_at, pe, rsn);
      rv.exp_pe  = pe;
      rv.exp_rsn = rsn;
      do_run(rv, $sformatf("run_rnd%0d", i));
    end

    send_cmd(OP_STOP, '0);
    @(negedge clk);
    chk("idle_stop_no_done", done, 0);
    chk("idle_stop_busy", busy, 0);
    @(posedge clk);
    #1;
    send_cmd(OP_NOP, '0);
    @(negedge clk);
    chk("idle_nop_no_done", done, 0);
    chk("idle_nop_busy", busy, 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < NB; i++) img[i] = 8'($urandom);
    exchange(0, 0, 1'b0, 100);
    for (int i = 0; i < NB; i++) img[i] = 8'($urandom);
    exchange(0, 0, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
